// File: rtl/johnson_counter_n.sv
// johnson_counter_n
// Parametrised bidirectional Johnson (twisted-ring) counter. The 2*WIDTH
// phases give a glitch-free sequencer. The block also provides parallel load,
// binary phase decode, a registered wrap pulse, and illegal-state detection
// with optional self-correction back to phase 0.
module johnson_counter_n #(
  parameter int WIDTH        = 4,
  parameter bit SELF_CORRECT = 1'b1,
  parameter int PW           = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             count_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic [PW-1:0]    phase,
  output logic             phase_valid,
  output logic             illegal,
  output logic             wrap
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] thermo;     // pattern folded so that ones sit at the LSB end
  logic [PW:0]      ones_cnt;   // one extra bit so that 2*WIDTH is representable
  logic [PW:0]      phase_full;
  logic             legal;
  logic             shifting;

  // Phase decode: fold MSB-anchored patterns onto LSB-anchored ones, then
  // check for a contiguous run of ones and count them.
  // NOTE: always_comb assigns every output a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    ones_cnt   = '0;
    thermo     = q_q[WIDTH-1] ? ~q_q : q_q;
    legal      = ((thermo & (thermo + WIDTH'(1))) == '0);
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + (PW + 1)'(q_q[i]);
    end
    phase_full = q_q[WIDTH-1] ? ((PW + 1)'(2 * WIDTH) - ones_cnt) : ones_cnt;
  end

  assign phase_valid = legal;
  assign illegal     = ~legal;
  assign phase       = legal ? phase_full[PW-1:0] : '0;

  // Next state by priority: load, then self-correct, then shift, else hold.
  // wrap is raised only for a real phase move across the 0 / 2*WIDTH-1 boundary.
  always_comb begin
    q_d      = q_q;
    wrap_d   = 1'b0;
    shifting = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (SELF_CORRECT && !legal) begin
      q_d = '0;
    end else if (en) begin
      shifting = 1'b1;
      if (count_mode) begin
        q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        wrap_d = legal && (phase_full[PW-1:0] == LAST_PHASE);
      end else begin
        q_d    = {~q_q[0], q_q[WIDTH-1:1]};
        wrap_d = legal && (phase_full[PW-1:0] == '0);
      end
    end
  end

  // State register with synchronous active-low clear.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge values and ordering between blocks does not matter.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q_out = q_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/johnson_counter_n.md
Name: johnson_counter_n

Overview:
Parametrised bidirectional Johnson (twisted-ring) counter. It is the successor to the fixed 4-bit Johnson counter. Adds the following to the basic count:
- configurable width
- parallel load
- binary phase decode
- a wrap pulse
- illegal-state detection with optional self-correction

Used as a glitch-free 2*WIDTH-phase sequencer and timing generator inside the FSM library.

Parameters:
WIDTH, 4, counter width in bits; legal range >= 2; sequence length is 2*WIDTH.
SELF_CORRECT, 1, when 1 an illegal state is forced to all-zeros on the next edge; when 0 illegal states are left to circulate.
PW, $clog2(2*WIDTH), phase output width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
clear_n  input  1  synchronous active-low reset
en  input  1  count enable
count_mode  input  1  1 = up (shift left, inject ~MSB at LSB), 0 = down (shift right, inject ~LSB at MSB)
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load=1
q_out  output  WIDTH  counter state, registered
phase  output  PW  binary phase index 0..2*WIDTH-1; 0 when illegal
phase_valid  output  1  1 when q_out is a legal Johnson pattern
illegal  output  1  equals ~phase_valid
wrap  output  1  one-cycle registered pulse on sequence wrap

Behaviour:
- One clock, one reset: clk, with synchronous active-low reset clear_n. No asynchronous paths.
- Reset values: clear_n low at a rising edge gives q_out=0, wrap=0; hence phase=0, phase_valid=1, illegal=0.
- Next-state priority, evaluated at each rising edge:
  1. clear_n=0: q_out <= 0.
  2. load=1: q_out <= load_val, accepted even if illegal.
  3. SELF_CORRECT=1 and illegal=1: q_out <= 0, regardless of en.
  4. en=1, count_mode=1: q_out <= {q_out[WIDTH-2:0], ~q_out[WIDTH-1]}.
  5. en=1, count_mode=0: q_out <= {~q_out[0], q_out[WIDTH-1:1]}.
  6. Otherwise hold.
- Legal states are exactly 2*WIDTH patterns:
  - Phase k in 0..WIDTH: the k LSBs are ones, the rest zeros.
  - Phase k in WIDTH+1..2*WIDTH-1: the (2*WIDTH-k) MSBs are ones, the rest zeros.
- Phase decode is combinational from q_out:
  - If q_out[WIDTH-1]=0: phase = popcount(q_out).
  - Else: phase = 2*WIDTH - popcount(q_out).
  - Valid only when the pattern is legal; otherwise phase=0 and phase_valid=0.
- Up counting advances the phase by +1 mod 2*WIDTH; down counting moves it by -1 mod 2*WIDTH.
- Direction change takes effect at the next enabled edge with no dead cycle. Example: phase 3 reversing to down gives phase 2.
- wrap is registered and is 1 for exactly the cycle after an edge where either:
  - an up shift moved phase 2*WIDTH-1 to phase 0, or
  - a down shift moved phase 0 to phase 2*WIDTH-1.
  In all other cycles wrap is 0.
- wrap never asserts on reset, load, self-correct or hold.
- Illegal states:
  - Reachable only through load, because a legal state always shifts to a legal state.
  - With SELF_CORRECT=0, shifting continues on the illegal pattern; illegal stays 1 until a load or reset.
- Load and en together: load wins and no shift occurs that cycle.
- Reset mid-count: clear_n low at any edge overrides load and en. The count restarts at phase 0 on the first enabled edge after clear_n returns high.
- Latency: q_out updates one edge after the control inputs are sampled. phase, phase_valid and illegal follow q_out combinationally. wrap is aligned with the new q_out.

Test Plan:
- Reset, WIDTH=4:
  - Stimulus: clear_n=0 for 2 edges, with en=1 and load=1 driving load_val=0111.
  - Response: q_out=0000, phase=0, wrap=0.
  - Also drive clear_n low between edges: q_out must not change until the next edge.
- Up cycle, WIDTH=4, en=1, count_mode=1, from 0000 over 8 edges:
  - q_out sequence: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - phase sequence: 1..7 then 0.
  - wrap=1 only after the 8th edge.
- Down and reversal, WIDTH=4, count_mode=0 from 0000:
  - First edge gives 1000, phase=7, wrap=1.
  - Next edge gives 1100.
  - Then set count_mode=1: next edge gives 1000, phase=7, wrap=0.
  - Then en=0 for 3 edges: q_out holds 1000.
- Illegal load, WIDTH=4, SELF_CORRECT=1:
  - load_val=0101 gives illegal=1, phase_valid=0, phase=0.
  - Next edge with en=1 gives q_out=0000, wrap=0.
  - Repeat with SELF_CORRECT=0, up mode: 0101 goes to 1011, and illegal remains 1.
- Load priority:
  - load=1 with load_val=1100 and en=1 at the same edge gives q_out=1100, phase=6, with no shift.
  - Next up edge gives 1000, phase=7.
- WIDTH=5, up, 10 edges from 00000:
  - Phase 5 is 11111; phase 9 is 10000.
  - 10th edge gives 00000 with wrap=1.
  - PW=4; phase never exceeds 9.
